// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    // Requesters and memory model drive the master side; the arbiter is the slave.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// running one fixed-latency transaction at a time with bounded IF starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_t            state, state_nxt;
    logic [LW-1:0]     lat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              own;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] if_rd;
    logic [DATA_W-1:0] dm_rd;
    logic              grant;
    logic              grant_if;
    logic              access;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_if  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    grant     = 1'b1;
                    // DM wins ties unless IF has waited through STARVE_MAX DM grants.
                    grant_if  = bus.if_req && (!bus.dm_req || starve_cnt == SW'(STARVE_MAX));
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (lat_cnt == '0) state_nxt = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            own        <= OWN_IF;
            a_we       <= 1'b0;
            a_addr     <= '0;
            a_wdata    <= '0;
            if_rd      <= '0;
            dm_rd      <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                own     <= grant_if ? OWN_IF : OWN_DM;
                a_addr  <= grant_if ? bus.if_addr : bus.dm_addr;
                a_we    <= !grant_if && bus.dm_we;
                a_wdata <= grant_if ? '0 : bus.dm_wdata;
                lat_cnt <= LW'(MEM_LAT - 1);
                if (grant_if)
                    starve_cnt <= '0;
                else if (bus.if_req && starve_cnt != SW'(STARVE_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (state == ST_ACCESS) begin
                if (lat_cnt != '0)
                    lat_cnt <= lat_cnt - 1'b1;
                else if (!a_we) begin
                    // Read data is only valid in the last access cycle; stores keep dm_rd.
                    if (own == OWN_DM) dm_rd <= bus.mem_rdata;
                    else               if_rd <= bus.mem_rdata;
                end
            end
        end
    end

    assign access        = (state == ST_ACCESS);
    assign bus.mem_en    = access;
    assign bus.mem_we    = access && a_we;
    assign bus.mem_addr  = access ? a_addr : '0;
    assign bus.mem_wdata = access ? a_wdata : '0;
    assign bus.if_ack    = (state == ST_RESP) && (own == OWN_IF);
    assign bus.dm_ack    = (state == ST_RESP) && (own == OWN_DM);
    assign bus.if_rdata  = if_rd;
    assign bus.dm_rdata  = dm_rd;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.owner     = own;

endmodule
